// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch/PC stage: next-PC select encodings, FSM states and
// default PC vectors.
package fetch_pc_unit_pkg;

  localparam logic [1:0] PCSRC_INC = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;
  localparam logic [1:0] PCSRC_EXC = 2'b11;

  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_0000;
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0180;

  typedef enum logic {
    StIdle,
    StWait
  } fetch_state_e;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Instruction-memory read handshake between the fetch stage (master) and memory (slave).
interface fetch_pc_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/pc_next_mux.sv
// Next-PC target select with word-alignment masking and misalignment detect.
module pc_next_mux
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] ExcVector = EXC_VECTOR_DEFAULT
) (
  input  logic [1:0]  pc_src_i,
  input  logic [31:0] pc_plus_inc_i,
  input  logic [31:0] branch_target_i,
  input  logic [31:0] jump_target_i,
  output logic [31:0] target_o,
  output logic        misalign_o
);

  logic [31:0] raw_target;

  always_comb begin
    raw_target = pc_plus_inc_i;
    unique case (pc_src_i)
      PCSRC_INC: raw_target = pc_plus_inc_i;
      PCSRC_BR:  raw_target = branch_target_i;
      PCSRC_JMP: raw_target = jump_target_i;
      PCSRC_EXC: raw_target = ExcVector;
      default:   raw_target = pc_plus_inc_i;
    endcase
  end

  assign target_o   = word_align(raw_target);
  assign misalign_o = |raw_target[1:0];

endmodule

// File: rtl/fetch_pc_unit.sv
// Program counter and instruction-fetch stage: runs the imem read handshake, latches IR and
// applies control-FSM PC writes while idle.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [31:0]            inc,
  input  logic                   start_fetch,
  fetch_pc_unit_if.master        imem,
  output logic [31:0]            ir,
  output logic                   fetch_done,
  output logic                   busy,
  output logic [31:0]            pc,
  output logic [31:0]            pc_plus_inc,
  input  logic                   pc_write,
  input  logic                   pc_write_cond,
  input  logic                   zero,
  input  logic [1:0]             pc_src,
  input  logic [31:0]            branch_target,
  input  logic [31:0]            jump_target,
  output logic                   misalign
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  ir_q, ir_d;
  logic         imem_req_q, imem_req_d;
  logic         fetch_done_q, fetch_done_d;
  logic         misalign_q, misalign_d;

  logic [31:0]  sel_target;
  logic         sel_misalign;

  assign pc_plus_inc = pc_q + inc;

  pc_next_mux #(
    .ExcVector (EXC_VECTOR)
  ) u_pc_next_mux (
    .pc_src_i        (pc_src),
    .pc_plus_inc_i   (pc_plus_inc),
    .branch_target_i (branch_target),
    .jump_target_i   (jump_target),
    .target_o        (sel_target),
    .misalign_o      (sel_misalign)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    imem_req_d   = imem_req_q;
    fetch_done_d = 1'b0;
    misalign_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        // A fetch request takes priority; any PC write in the same cycle is dropped.
        if (start_fetch) begin
          state_d    = StWait;
          imem_req_d = 1'b1;
        end else if (pc_write || (pc_write_cond && zero)) begin
          pc_d       = sel_target;
          misalign_d = sel_misalign;
        end
      end
      StWait: begin
        if (imem.imem_ack) begin
          ir_d         = imem.imem_rdata;
          pc_d         = pc_plus_inc;
          fetch_done_d = 1'b1;
          imem_req_d   = 1'b0;
          state_d      = StIdle;
        end
      end
      default: begin
        state_d    = StIdle;
        imem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      ir_q         <= 32'h0;
      imem_req_q   <= 1'b0;
      fetch_done_q <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      imem_req_q   <= imem_req_d;
      fetch_done_q <= fetch_done_d;
      misalign_q   <= misalign_d;
    end
  end

  assign imem.imem_req  = imem_req_q;
  assign imem.imem_addr = pc_q;
  assign pc             = pc_q;
  assign ir             = ir_q;
  assign fetch_done     = fetch_done_q;
  assign misalign       = misalign_q;
  assign busy           = (state_q == StWait);

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: fetch handshake, PC writes, wrap-around and async reset.
module tb_fetch_pc_unit;

  logic        clk;
  logic        rst_n;
  logic [31:0] inc;
  logic        start_fetch;
  logic [31:0] ir;
  logic        fetch_done;
  logic        busy;
  logic [31:0] pc;
  logic [31:0] pc_plus_inc;
  logic        pc_write;
  logic        pc_write_cond;
  logic        zero;
  logic [1:0]  pc_src;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        misalign;

  int tests;
  int fails;

  fetch_pc_unit_if imem_if ();

  fetch_pc_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inc           (inc),
    .start_fetch   (start_fetch),
    .imem          (imem_if.master),
    .ir            (ir),
    .fetch_done    (fetch_done),
    .busy          (busy),
    .pc            (pc),
    .pc_plus_inc   (pc_plus_inc),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .zero          (zero),
    .pc_src        (pc_src),
    .branch_target (branch_target),
    .jump_target   (jump_target),
    .misalign      (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    inc = 32'd4;
    start_fetch = 1'b0;
    pc_write = 1'b0;
    pc_write_cond = 1'b0;
    zero = 1'b0;
    pc_src = 2'b00;
    branch_target = 32'h0;
    jump_target = 32'h0;
    imem_if.imem_rdata = 32'h0;
    imem_if.imem_ack = 1'b0;

    #3;
    chk("rst_pc", pc, 32'h0);
    chk("rst_ir", ir, 32'h0);
    chk("rst_req", {31'h0, imem_if.imem_req}, 32'h0);
    chk("rst_done", {31'h0, fetch_done}, 32'h0);
    chk("rst_misalign", {31'h0, misalign}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single-cycle-ack fetch
    start_fetch = 1'b1;
    imem_if.imem_rdata = 32'h8C01_0004;
    tick();
    chk("f1_req", {31'h0, imem_if.imem_req}, 32'h1);
    chk("f1_addr", imem_if.imem_addr, 32'h0);
    chk("f1_busy", {31'h0, busy}, 32'h1);
    chk("f1_nodone", {31'h0, fetch_done}, 32'h0);
    start_fetch = 1'b0;
    imem_if.imem_ack = 1'b1;
    tick();
    chk("f1_ir", ir, 32'h8C01_0004);
    chk("f1_pc", pc, 32'h4);
    chk("f1_done", {31'h0, fetch_done}, 32'h1);
    chk("f1_req_drop", {31'h0, imem_if.imem_req}, 32'h0);
    imem_if.imem_ack = 1'b0;
    tick();
    chk("f1_done_pulse", {31'h0, fetch_done}, 32'h0);
    chk("f1_ir_hold", ir, 32'h8C01_0004);

    // Fetch with three wait cycles; PC writes and start_fetch during WAIT are ignored
    start_fetch = 1'b1;
    tick();
    chk("f2_busy0", {31'h0, busy}, 32'h1);
    pc_write = 1'b1;
    pc_src = 2'b10;
    jump_target = 32'h0000_0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("f2_req_wait", {31'h0, imem_if.imem_req}, 32'h1);
      chk("f2_addr_wait", imem_if.imem_addr, 32'h4);
      chk("f2_busy_wait", {31'h0, busy}, 32'h1);
      chk("f2_nodone_wait", {31'h0, fetch_done}, 32'h0);
    end
    start_fetch = 1'b0;
    pc_write = 1'b0;
    imem_if.imem_ack = 1'b1;
    imem_if.imem_rdata = 32'h1234_5678;
    tick();
    chk("f2_pc", pc, 32'h8);
    chk("f2_ir", ir, 32'h1234_5678);
    chk("f2_done", {31'h0, fetch_done}, 32'h1);
    imem_if.imem_ack = 1'b0;
    tick();
    chk("f2_done_pulse", {31'h0, fetch_done}, 32'h0);
    chk("f2_pc_once", pc, 32'h8);
    chk("f2_idle", {31'h0, busy}, 32'h0);

    // Conditional branch
    pc_write = 1'b1;
    pc_src = 2'b01;
    branch_target = 32'h10;
    tick();
    chk("br_setup", pc, 32'h10);
    pc_write = 1'b0;
    pc_write_cond = 1'b1;
    zero = 1'b0;
    branch_target = 32'h40;
    tick();
    chk("br_not_taken", pc, 32'h10);
    zero = 1'b1;
    tick();
    chk("br_taken", pc, 32'h40);
    chk("br_aligned", {31'h0, misalign}, 32'h0);
    pc_write_cond = 1'b0;
    zero = 1'b0;

    // Misaligned jump, exception vector, sequential select
    pc_write = 1'b1;
    pc_src = 2'b10;
    jump_target = 32'h0000_0123;
    tick();
    chk("jmp_pc", pc, 32'h0000_0120);
    chk("jmp_misalign", {31'h0, misalign}, 32'h1);
    pc_write = 1'b0;
    tick();
    chk("jmp_misalign_pulse", {31'h0, misalign}, 32'h0);
    chk("jmp_pc_hold", pc, 32'h0000_0120);
    pc_write = 1'b1;
    pc_src = 2'b11;
    tick();
    chk("exc_pc", pc, 32'h0000_0180);
    pc_src = 2'b00;
    tick();
    chk("inc_pc", pc, 32'h0000_0184);
    pc_write = 1'b0;

    // Wrap-around on fetch
    pc_write = 1'b1;
    pc_src = 2'b10;
    jump_target = 32'hFFFF_FFFC;
    tick();
    chk("wrap_setup", pc, 32'hFFFF_FFFC);
    chk("wrap_plus_inc", pc_plus_inc, 32'h0);
    pc_write = 1'b0;
    start_fetch = 1'b1;
    tick();
    start_fetch = 1'b0;
    imem_if.imem_ack = 1'b1;
    imem_if.imem_rdata = 32'hAAAA_5555;
    tick();
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_done", {31'h0, fetch_done}, 32'h1);
    imem_if.imem_ack = 1'b0;
    tick();

    // Fetch beats a simultaneous PC write
    start_fetch = 1'b1;
    pc_write = 1'b1;
    pc_src = 2'b10;
    jump_target = 32'h0000_0200;
    tick();
    chk("prio_busy", {31'h0, busy}, 32'h1);
    chk("prio_pc", pc, 32'h0);
    start_fetch = 1'b0;
    pc_write = 1'b0;
    imem_if.imem_ack = 1'b1;
    tick();
    chk("prio_pc_after", pc, 32'h4);
    imem_if.imem_ack = 1'b0;
    tick();

    // ack while idle is ignored
    imem_if.imem_ack = 1'b1;
    imem_if.imem_rdata = 32'h5A5A_5A5A;
    tick();
    chk("idle_ack_done", {31'h0, fetch_done}, 32'h0);
    chk("idle_ack_ir", ir, 32'hAAAA_5555);
    imem_if.imem_ack = 1'b0;

    // Reset in the middle of a fetch
    pc_write = 1'b1;
    pc_src = 2'b10;
    jump_target = 32'h20;
    tick();
    pc_write = 1'b0;
    start_fetch = 1'b1;
    tick();
    chk("mid_addr", imem_if.imem_addr, 32'h20);
    chk("mid_req", {31'h0, imem_if.imem_req}, 32'h1);
    start_fetch = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", {31'h0, imem_if.imem_req}, 32'h0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_ir", ir, 32'h0);
    #2;
    rst_n = 1'b1;
    imem_if.imem_ack = 1'b1;
    imem_if.imem_rdata = 32'hDEAD_BEEF;
    tick();
    chk("post_rst_ir", ir, 32'h0);
    chk("post_rst_done", {31'h0, fetch_done}, 32'h0);
    chk("post_rst_pc", pc, 32'h0);
    imem_if.imem_ack = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
Program-counter and instruction-fetch stage of the multi-cycle CPU. It holds the PC and runs the instruction-memory read handshake in the IF cycle, latching the IR when the read completes. It advances the PC by the increment word supplied by the constant-4 generator. Outside a fetch, it applies the PCWrite/PCWriteCond updates that the main control FSM issues.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
EXC_VECTOR, 32'h0000_0180, target selected when pc_src=2'b11.

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
inc  in  32  PC increment word, driven by the constant-4 generator (normally 32'd4)
start_fetch  in  1  control FSM requests an instruction fetch
imem_req  out  1  instruction memory read request
imem_addr  out  32  instruction memory address; equals pc
imem_rdata  in  32  instruction word; valid when imem_ack=1
imem_ack  in  1  memory read complete
ir  out  32  instruction register
fetch_done  out  1  one-cycle pulse: ir and pc were updated this edge
busy  out  1  fetch in progress
pc  out  32  current program counter
pc_plus_inc  out  32  combinational pc+inc
pc_write  in  1  unconditional PC update
pc_write_cond  in  1  PC update qualified by zero
zero  in  1  ALU zero flag
pc_src  in  2  next-PC select: 00 pc+inc, 01 branch_target, 10 jump_target, 11 EXC_VECTOR
branch_target  in  32  branch target from ALUOut
jump_target  in  32  jump target from concat logic
misalign  out  1  one-cycle pulse: a selected target had nonzero bits [1:0]

Behaviour:
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, ir=0, imem_req=0, fetch_done=0, misalign=0. Every output holds these values while reset is asserted.
- Arithmetic: pc_plus_inc = pc+inc modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0 with no flag. inc is not checked.
- FSM states: IDLE, WAIT.
  - IDLE and start_fetch=1: the next edge moves to WAIT and sets imem_req=1.
  - WAIT: imem_req stays 1 and imem_addr=pc until imem_ack=1 is sampled.
  - On that edge: ir<=imem_rdata, pc<=pc+inc, fetch_done<=1 for one cycle, imem_req<=0, state<=IDLE.
- Fetch latency: minimum 2 edges from start_fetch to fetch_done when imem_ack=1 in the first WAIT cycle. Each extra wait cycle adds one edge.
- imem_ack sampled in IDLE: ignored.
- busy = (state==WAIT).
- start_fetch while busy: ignored. No queuing.
- PC update, evaluated only in IDLE with start_fetch=0:
  - Update when pc_write=1, or when pc_write_cond=1 and zero=1.
  - pc <= selected target with bits [1:0] forced to 0.
  - misalign pulses for one cycle if the selected target had nonzero bits [1:0].
  - pc_write and pc_write_cond together behave as pc_write.
- Simultaneous events:
  - start_fetch with pc_write in IDLE: the fetch wins and the PC update is dropped.
  - pc_write/pc_write_cond in WAIT: ignored.
- ir holds its value between fetches.
- Reset mid-fetch: imem_req drops immediately (async). A later imem_ack is ignored because state=IDLE.

Decomposition:
- Shared cpu package:
  - pc_src encodings: PCSRC_INC, PCSRC_BR, PCSRC_JMP, PCSRC_EXC.
  - FSM state encoding.
  - RESET_PC and EXC_VECTOR defaults.
- One sub-module, pc_next_mux: the combinational 4:1 target select plus alignment masking and the misalign detect. The FSM and registers stay in the top.

Test Plan:
- Reset, then start_fetch=1 for 1 cycle, imem_ack=1 in the first WAIT cycle with imem_rdata=32'h8C01_0004 -> imem_req=1 for 1 cycle with imem_addr=0; then ir=32'h8C01_0004, pc=4, one fetch_done pulse.
- Fetch with imem_ack held low for 3 WAIT cycles -> imem_req stays 1, imem_addr stays constant, busy=1 for 4 cycles, single fetch_done, pc advances once.
- pc=32'h10, pc_write_cond=1, pc_src=01, branch_target=32'h40: zero=0 -> pc stays 32'h10; zero=1 -> pc=32'h40.
- pc_write=1, pc_src=10, jump_target=32'h0000_0123 -> pc=32'h0000_0120, misalign pulses once. pc_src=11 -> pc=32'h0000_0180.
- pc=32'hFFFF_FFFC, complete a fetch -> pc=0. Separately, start_fetch with pc_write=1 in the same IDLE cycle -> fetch proceeds and the target is ignored.
- Drop rst_n in the WAIT state with pc=32'h20 -> imem_req=0 and pc=0 immediately. A subsequent imem_ack=1 leaves ir=0 with no fetch_done.
